// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: FSM state encodings, PC step and bubble counter sizing.
// Used by fetch_pc_unit and fetch_bubble_counter.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_RUN    = 2'd0,
        FETCH_YIELD  = 2'd1,
        FETCH_FLUSH  = 2'd2,
        FETCH_HALTED = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_INCREMENT = 32'd4;

    localparam int unsigned BUBBLE_W = 3;
    localparam logic [BUBBLE_W-1:0] BUBBLE_ONE = BUBBLE_W'(1);

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Request/fetch signal bundle between the fetch PC unit and its neighbours.
// align_fault exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_pc_unit_if;

    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_access_req;
    logic        halt_req;
    logic [31:0] fetch_address;
    logic        fetch_grant;
    logic        block_fetch;
    logic [31:0] fetch_pc;
    logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    // The fetch unit itself is the slave: it serves redirect/yield/halt requests.
    modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
        output align_fault,
`endif
        input  branch_taken,
        input  branch_target,
        input  mem_access_req,
        input  halt_req,
        output fetch_address,
        output fetch_grant,
        output block_fetch,
        output fetch_pc,
        output halted
    );

    modport master (
`ifdef FETCH_ALIGN_CHECK_EN
        input  align_fault,
`endif
        output branch_taken,
        output branch_target,
        output mem_access_req,
        output halt_req,
        input  fetch_address,
        input  fetch_grant,
        input  block_fetch,
        input  fetch_pc,
        input  halted
    );

endinterface

// File: rtl/fetch_pc_unit_bubble_counter.sv
// Branch bubble counter: loads the configured bubble count on a redirect and
// counts down towards zero, never wrapping below zero.
module fetch_bubble_counter
    import fetch_pc_unit_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [BUBBLE_W-1:0] load_value,
    input  logic                decrement,
    output logic [BUBBLE_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - BUBBLE_ONE;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, memory-port arbitration and redirect/halt FSM ahead of fetch stage 0.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned branch targets halt the unit and raise align_fault.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned BRANCH_BUBBLES = 1
) (
    input  logic           clock,
    input  logic           reset,
    fetch_pc_unit_if.slave bus
);

    localparam logic [BUBBLE_W-1:0] BUBBLE_LOAD = BUBBLE_W'(BRANCH_BUBBLES);

    fetch_state_t        state;
    fetch_state_t        next_state;
    logic [31:0]         pc;
    logic [31:0]         pc_next;
    logic                bubble_load;
    logic                bubble_dec;
    logic [BUBBLE_W-1:0] bubble_count;
`ifdef FETCH_ALIGN_CHECK_EN
    logic                fault_set;
    logic                align_fault_q;
`endif

    fetch_bubble_counter u_bubble_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (bubble_load),
        .load_value (BUBBLE_LOAD),
        .decrement  (bubble_dec),
        .count      (bubble_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH_RUN;
            pc    <= RESET_VECTOR;
        end else begin
            state <= next_state;
            pc    <= pc_next;
        end
    end

    // Priority: halt, then redirect, then memory-stage yield, then normal sequencing.
    always_comb begin
        next_state  = state;
        pc_next     = pc;
        bubble_load = 1'b0;
        bubble_dec  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_set   = 1'b0;
`endif
        if (bus.halt_req) begin
            next_state = FETCH_HALTED;
        end else if (state == FETCH_HALTED) begin
            next_state = FETCH_HALTED;
        end else if (bus.branch_taken) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (bus.branch_target[1:0] != 2'b00) begin
                next_state = FETCH_HALTED;
                fault_set  = 1'b1;
            end else
`endif
            begin
                pc_next     = bus.branch_target;
                bubble_load = 1'b1;
                if (bus.mem_access_req) begin
                    next_state = FETCH_YIELD;
                end else if (BUBBLE_LOAD != '0) begin
                    next_state = FETCH_FLUSH;
                end else begin
                    next_state = FETCH_RUN;
                end
            end
        end else begin
            case (state)
                FETCH_RUN: begin
                    pc_next = pc + PC_INCREMENT;
                    if (bus.mem_access_req) begin
                        next_state = FETCH_YIELD;
                    end
                end
                FETCH_YIELD: begin
                    bubble_dec = 1'b1;
                    if (!bus.mem_access_req) begin
                        next_state = (bubble_count > BUBBLE_ONE) ? FETCH_FLUSH : FETCH_RUN;
                    end
                end
                FETCH_FLUSH: begin
                    bubble_dec = 1'b1;
                    if (bus.mem_access_req) begin
                        next_state = FETCH_YIELD;
                    end else if (bubble_count <= BUBBLE_ONE) begin
                        next_state = FETCH_RUN;
                    end
                end
                default: begin
                    next_state = state;
                end
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            align_fault_q <= 1'b0;
        end else if (fault_set) begin
            align_fault_q <= 1'b1;
        end
    end

    assign bus.align_fault = align_fault_q;
`endif

    assign bus.fetch_address = pc;
    assign bus.fetch_pc      = pc;
    assign bus.fetch_grant   = (state == FETCH_RUN);
    assign bus.block_fetch   = (state != FETCH_RUN);
    assign bus.halted        = (state == FETCH_HALTED);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: three instances with different reset vectors and bubble counts
// share one stimulus stream and are checked against a per-instance behavioural model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RV_A = 32'h0000_0100;
    localparam logic [31:0] RV_B = 32'h0000_0040;
    localparam logic [31:0] RV_C = 32'hFFFF_FFF8;
    localparam int unsigned BB_A = 1;
    localparam int unsigned BB_B = 2;
    localparam int unsigned BB_C = 0;

    localparam int M_RUN  = 0;
    localparam int M_YLD  = 1;
    localparam int M_FLSH = 2;
    localparam int M_HALT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        mem_access_req = 1'b0;
    logic        halt_req = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    fetch_pc_unit_if if_a ();
    fetch_pc_unit_if if_b ();
    fetch_pc_unit_if if_c ();

    assign if_a.branch_taken   = branch_taken;
    assign if_a.branch_target  = branch_target;
    assign if_a.mem_access_req = mem_access_req;
    assign if_a.halt_req       = halt_req;
    assign if_b.branch_taken   = branch_taken;
    assign if_b.branch_target  = branch_target;
    assign if_b.mem_access_req = mem_access_req;
    assign if_b.halt_req       = halt_req;
    assign if_c.branch_taken   = branch_taken;
    assign if_c.branch_target  = branch_target;
    assign if_c.mem_access_req = mem_access_req;
    assign if_c.halt_req       = halt_req;

    fetch_pc_unit #(.RESET_VECTOR(RV_A), .BRANCH_BUBBLES(BB_A)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
    fetch_pc_unit #(.RESET_VECTOR(RV_B), .BRANCH_BUBBLES(BB_B)) dut_b (.clock(clock), .reset(reset), .bus(if_b));
    fetch_pc_unit #(.RESET_VECTOR(RV_C), .BRANCH_BUBBLES(BB_C)) dut_c (.clock(clock), .reset(reset), .bus(if_c));

    logic [31:0] obs_addr  [3];
    logic [31:0] obs_pc    [3];
    logic [2:0]  obs_flags [3];

    assign obs_addr[0]  = if_a.fetch_address;
    assign obs_addr[1]  = if_b.fetch_address;
    assign obs_addr[2]  = if_c.fetch_address;
    assign obs_pc[0]    = if_a.fetch_pc;
    assign obs_pc[1]    = if_b.fetch_pc;
    assign obs_pc[2]    = if_c.fetch_pc;
    assign obs_flags[0] = {if_a.fetch_grant, if_a.block_fetch, if_a.halted};
    assign obs_flags[1] = {if_b.fetch_grant, if_b.block_fetch, if_b.halted};
    assign obs_flags[2] = {if_c.fetch_grant, if_c.block_fetch, if_c.halted};

`ifdef FETCH_ALIGN_CHECK_EN
    logic obs_fault [3];
    assign obs_fault[0] = if_a.align_fault;
    assign obs_fault[1] = if_b.align_fault;
    assign obs_fault[2] = if_c.align_fault;
`endif

    logic [31:0] rv [3];
    int          bb [3];
    logic [31:0] m_pc [3];
    int          m_mode [3];
    int          m_bub [3];
    logic        m_fault [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pc[i]    = rv[i];
            m_mode[i]  = M_RUN;
            m_bub[i]   = 0;
            m_fault[i] = 1'b0;
        end
    endtask

    // Bubbles remaining are spent one per stalled cycle; a yield that ends with none left resumes fetching.
    task automatic model_step(input logic bt, input logic [31:0] tgt, input logic mr, input logic hr);
        for (int i = 0; i < 3; i++) begin
            if (hr) begin
                m_mode[i] = M_HALT;
            end else if (m_mode[i] == M_HALT) begin
                m_mode[i] = M_HALT;
            end else if (bt) begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (tgt[1:0] != 2'b00) begin
                    m_mode[i]  = M_HALT;
                    m_fault[i] = 1'b1;
                    continue;
                end
`endif
                m_pc[i]  = tgt;
                m_bub[i] = bb[i];
                m_mode[i] = mr ? M_YLD : ((bb[i] != 0) ? M_FLSH : M_RUN);
            end else if (m_mode[i] == M_RUN) begin
                m_pc[i] = m_pc[i] + 32'd4;
                if (mr) m_mode[i] = M_YLD;
            end else begin
                if (m_bub[i] > 0) m_bub[i] = m_bub[i] - 1;
                if (mr) m_mode[i] = M_YLD;
                else m_mode[i] = (m_bub[i] > 0) ? M_FLSH : M_RUN;
            end
        end
    endtask

    task automatic applyStimulus(input logic bt, input logic [31:0] tgt, input logic mr, input logic hr);
        branch_taken   = bt;
        branch_target  = tgt;
        mem_access_req = mr;
        halt_req       = hr;
        model_step(bt, tgt, mr, hr);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        branch_taken   = 1'b0;
        mem_access_req = 1'b0;
        halt_req       = 1'b0;
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_addr[i] !== rv[i] || obs_pc[i] !== rv[i]) begin
                miscompares++;
                $display("[TB] FAIL reset inst%0d addr/pc got %h/%h expected %h", i, obs_addr[i], obs_pc[i], rv[i]);
            end
            vectors++;
            if (obs_flags[i] !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL reset inst%0d grant/block/halted got %b expected 100", i, obs_flags[i]);
            end
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_sequential_fetch();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (obs_addr[0] !== 32'h100 + 32'(4 * (k + 1)) || obs_flags[0] !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL seq_fetch instA step%0d got %h/%b expected %h/100", k, obs_addr[0], obs_flags[0], 32'h100 + 32'(4 * (k + 1)));
            end
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs_addr[i] !== m_pc[i] || obs_pc[i] !== m_pc[i]) begin
                    miscompares++;
                    $display("[TB] FAIL seq_fetch inst%0d addr/pc got %h/%h expected %h", i, obs_addr[i], obs_pc[i], m_pc[i]);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_addr [3];
        logic [2:0]  exp_flags [3];
        exp_addr  = '{32'h2000, 32'h2000, 32'h2004};
        exp_flags = '{3'b010, 3'b100, 3'b100};
        for (int k = 0; k < 3; k++) begin
            applyStimulus(k == 0, 32'h2000, 1'b0, 1'b0);
            vectors++;
            if (obs_addr[0] !== exp_addr[k] || obs_flags[0] !== exp_flags[k]) begin
                miscompares++;
                $display("[TB] FAIL branch instA step%0d got %h/%b expected %h/%b", k, obs_addr[0], obs_flags[0], exp_addr[k], exp_flags[k]);
            end
            for (int i = 0; i < 3; i++) begin
                automatic logic [2:0] ef = {m_mode[i] == M_RUN, m_mode[i] != M_RUN, m_mode[i] == M_HALT};
                vectors++;
                if (obs_addr[i] !== m_pc[i] || obs_flags[i] !== ef) begin
                    miscompares++;
                    $display("[TB] FAIL branch inst%0d got %h/%b expected %h/%b", i, obs_addr[i], obs_flags[i], m_pc[i], ef);
                end
            end
        end
    endtask

    task automatic test_mem_yield();
        logic [31:0] exp_addr [5];
        logic [2:0]  exp_flags [5];
        exp_addr  = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h48};
        exp_flags = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 32'h0, k < 3, 1'b0);
            vectors++;
            if (obs_addr[1] !== exp_addr[k] || obs_flags[1] !== exp_flags[k]) begin
                miscompares++;
                $display("[TB] FAIL mem_yield instB step%0d got %h/%b expected %h/%b", k, obs_addr[1], obs_flags[1], exp_addr[k], exp_flags[k]);
            end
            for (int i = 0; i < 3; i++) begin
                automatic logic [2:0] ef = {m_mode[i] == M_RUN, m_mode[i] != M_RUN, m_mode[i] == M_HALT};
                vectors++;
                if (obs_addr[i] !== m_pc[i] || obs_flags[i] !== ef) begin
                    miscompares++;
                    $display("[TB] FAIL mem_yield inst%0d got %h/%b expected %h/%b", i, obs_addr[i], obs_flags[i], m_pc[i], ef);
                end
            end
        end
    endtask

    task automatic test_branch_with_yield();
        logic [31:0] exp_addr [4];
        logic [2:0]  exp_flags [4];
        exp_addr  = '{32'h3000, 32'h3000, 32'h3000, 32'h3004};
        exp_flags = '{3'b010, 3'b010, 3'b100, 3'b100};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k == 0, 32'h3000, k == 0, 1'b0);
            vectors++;
            if (obs_addr[1] !== exp_addr[k] || obs_flags[1] !== exp_flags[k]) begin
                miscompares++;
                $display("[TB] FAIL branch_yield instB step%0d got %h/%b expected %h/%b", k, obs_addr[1], obs_flags[1], exp_addr[k], exp_flags[k]);
            end
            for (int i = 0; i < 3; i++) begin
                automatic logic [2:0] ef = {m_mode[i] == M_RUN, m_mode[i] != M_RUN, m_mode[i] == M_HALT};
                vectors++;
                if (obs_addr[i] !== m_pc[i] || obs_flags[i] !== ef) begin
                    miscompares++;
                    $display("[TB] FAIL branch_yield inst%0d got %h/%b expected %h/%b", i, obs_addr[i], obs_flags[i], m_pc[i], ef);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (obs_addr[2] !== 32'h0000_0000 || obs_flags[2] !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL wrap instC got %h/%b expected 00000000/100", obs_addr[2], obs_flags[2]);
        end
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_addr[i] !== m_pc[i]) begin
                miscompares++;
                $display("[TB] FAIL wrap_branch inst%0d got %h expected %h", i, obs_addr[i], m_pc[i]);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h5000, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (obs_addr[0] !== 32'h104 || obs_flags[0] !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL halt instA got %h/%b expected 00000104/011", obs_addr[0], obs_flags[0]);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_addr[i] !== m_pc[i] || obs_flags[i] !== 3'b011) begin
                miscompares++;
                $display("[TB] FAIL halt inst%0d got %h/%b expected %h/011", i, obs_addr[i], obs_flags[i], m_pc[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_addr[i] !== rv[i] || obs_flags[i] !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL halt_exit inst%0d got %h/%b expected %h/100", i, obs_addr[i], obs_flags[i], rv[i]);
            end
        end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_align_fault();
        do_reset();
        applyStimulus(1'b1, 32'h1002, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_fault[i] !== 1'b1 || obs_flags[i] !== 3'b011 || obs_addr[i] !== rv[i]) begin
                miscompares++;
                $display("[TB] FAIL align inst%0d fault/flags/addr got %b/%b/%h expected 1/011/%h", i, obs_fault[i], obs_flags[i], obs_addr[i], rv[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_fault[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL align_clear inst%0d got %b expected 0", i, obs_fault[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 96) == 0) begin
                // Reset lands mid-cycle, away from any edge, to exercise the asynchronous clear.
                #2;
                reset = 1'b1;
                branch_taken = 1'b0;
                mem_access_req = 1'b0;
                halt_req = 1'b0;
                model_reset();
                #1;
                for (int i = 0; i < 3; i++) begin
                    vectors++;
                    if (obs_addr[i] !== rv[i] || obs_flags[i] !== 3'b100) begin
                        miscompares++;
                        $display("[TB] FAIL rand_reset inst%0d got %h/%b expected %h/100", i, obs_addr[i], obs_flags[i], rv[i]);
                    end
                end
                @(negedge clock);
                reset = 1'b0;
            end else begin
                automatic logic [31:0] tgt = $urandom();
                if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
                applyStimulus($urandom_range(0, 7) == 0, tgt, $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0);
                for (int i = 0; i < 3; i++) begin
                    automatic logic [2:0] ef = {m_mode[i] == M_RUN, m_mode[i] != M_RUN, m_mode[i] == M_HALT};
                    vectors++;
                    if (obs_addr[i] !== m_pc[i] || obs_pc[i] !== m_pc[i] || obs_flags[i] !== ef) begin
                        miscompares++;
                        $display("[TB] FAIL random n%0d inst%0d addr/pc/flags got %h/%h/%b expected %h/%b", n, i, obs_addr[i], obs_pc[i], obs_flags[i], m_pc[i], ef);
                    end
`ifdef FETCH_ALIGN_CHECK_EN
                    vectors++;
                    if (obs_fault[i] !== m_fault[i]) begin
                        miscompares++;
                        $display("[TB] FAIL random_fault n%0d inst%0d got %b expected %b", n, i, obs_fault[i], m_fault[i]);
                    end
`endif
                end
            end
        end
    endtask

    initial begin
        rv = '{RV_A, RV_B, RV_C};
        bb = '{int'(BB_A), int'(BB_B), int'(BB_C)};
        model_reset();
        test_reset();
        test_sequential_fetch();
        test_branch();
        test_mem_yield();
        test_branch_with_yield();
        test_wrap();
        test_halt();
`ifdef FETCH_ALIGN_CHECK_EN
        test_align_fault();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
